umi_mport_ram: RTL and testbench
================================

# umi_mport_ram

Multi-port UMI memory endpoint: N independent UMI device ports share one single-ported RAM of RAMDEPTH words × DW bits. A per-cycle arbiter picks one request, executes read or write in the RAM, and returns the UMI response on the originating port. It serves as a simulation and test memory behind UMI hosts and switches.

## Interface
- N, 5: number of UMI device ports.
- CW, 32: command width.
- AW, 64: address width.
- DW, 256: data width; one RAM word = DW/8 bytes.
- RAMDEPTH, 512: RAM words, power of 2.
- CTRLW, 8: SRAM control bus width.

- clk  in  1  clock; everything on rising edge.
- nreset  in  1  reset, asynchronous, active-low.
- mode  in  2  arbitration: 00 fixed priority, lowest index wins; 01/10/11 round-robin.
- sram_ctrl  in  CTRLW  macro control passthrough, no functional effect.
- udev_req_valid / _ready  in / out  N  request handshake per port.
- udev_req_cmd  in  N*CW  request command per port.
- udev_req_dstaddr, udev_req_srcaddr  in  N*AW  per-port addresses.
- udev_req_data  in  N*DW  per-port write data.
- udev_resp_valid / _ready  out / in  N  response handshake per port.
- udev_resp_cmd  out  N*CW; udev_resp_dstaddr, udev_resp_srcaddr  out  N*AW; udev_resp_data  out  N*DW.

## Operation
- cmd fields: opcode [4:0], size [7:5], len [15:8]. Bytes = (len+1)<<size.
- Request opcodes: READ 0x01, WRITE 0x03, POSTED 0x05. Response opcodes: RESP_READ 0x02, RESP_WRITE 0x04.
- Word index = dstaddr[log2(DW/8) +: log2(RAMDEPTH)]. Upper bits are ignored, so addresses alias modulo RAMDEPTH*DW/8. Byte offset = dstaddr[log2(DW/8)-1:0].
- A transfer never crosses a word boundary. Bytes beyond the end of the word are dropped on write and returned as 0 on read.
- WRITE/POSTED: write the data LSB-aligned bytes to the word at the byte offset, using byte enables. Other bytes are unchanged.
- READ: return the addressed bytes LSB-aligned in resp_data. Upper bytes are 0.
- Responses (READ, WRITE only; POSTED produces none):
  - resp_cmd = request cmd with the opcode replaced.
  - resp_dstaddr = request srcaddr; resp_srcaddr = request dstaddr.
  - WRITE response data = 0.
- Eligibility: a port is eligible when req_valid=1 and either the opcode is POSTED or its response register is empty or being drained this cycle (resp_valid & resp_ready).
- At most one grant per cycle. req_ready[i] = grant[i]. The grant depends combinationally only on valid, cmd and response state, never on req_ready.
- Round-robin: search starts at the index after the last granted port. The pointer advances only on an accepted request.
- Other opcodes: accepted and dropped, no RAM access, no response.
- RAM contents are not reset; reading unwritten words gives undefined data.

## Timing
- Reset values: udev_resp_valid=0, udev_req_ready=0, resp cmd/addr/data=0, RR pointer=port N-1 (so port 0 is searched first).
- Read/write response latency: 1 cycle. Request accepted at edge k gives resp_valid high from edge k through the edge where resp_ready=1.
- Response holds stable while resp_valid & !resp_ready.
- Per-port throughput: one request per cycle if resp_ready is held high. Aggregate throughput: one request per cycle.
- Write then read to the same word on consecutive cycles returns the new data.
- Reset mid-operation: pending responses are discarded and valids drop immediately.

## Configuration
- UMI_RAM_ERR_RESP_EN:
  - Defined: unsupported request opcodes with cmd[4:0] odd and ≠0x05 return a response with opcode 0x0E (RESP_ERROR) and data 0, on the same 1-cycle latency and handshake.
  - Undefined: such requests are silently dropped.

## Test plan
- Port 0 WRITE, size=3, len=0, dstaddr 0x40, srcaddr 0x1000, data 0x1122334455667788 -> next cycle port 0 RESP_WRITE, dstaddr 0x1000, srcaddr 0x40. Then port 3 READ of the same address -> resp_data 0x1122334455667788.
- POSTED write of byte 0xAB to 0x45, then READ size=0 at 0x45 -> 0xAB. No response follows the posted write, and neighbouring bytes 0x40–0x44 are unchanged.
- All 5 ports assert READ simultaneously, mode=10, resp_ready=1 -> accepted in order 0,1,2,3,4, one per cycle. With mode=00 and port 0 streaming, ports 1–4 starve.
- Port 2 resp_ready=0 after a READ -> its response holds stable and port 2 req_ready stays 0 for non-posted requests, while other ports proceed.
- Write 0x5A5A at 0x0, read at 0x4000 (RAMDEPTH*32) -> 0x5A5A (aliasing).
- Assert nreset low while responses are pending -> all resp_valid=0 asynchronously. After release, the first READ completes normally.

Source files
------------

// File: rtl/umi_mport_ram_if.sv
// rtl/umi_mport_ram_if.sv - UMI device-port bundle (N ports, flattened request/response channels)
interface umi_mport_ram_if #(
  parameter int N  = 5,
  parameter int CW = 32,
  parameter int AW = 64,
  parameter int DW = 256
);
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*CW-1:0] req_cmd;
  logic [N*AW-1:0] req_dstaddr;
  logic [N*AW-1:0] req_srcaddr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    resp_valid;
  logic [N-1:0]    resp_ready;
  logic [N*CW-1:0] resp_cmd;
  logic [N*AW-1:0] resp_dstaddr;
  logic [N*AW-1:0] resp_srcaddr;
  logic [N*DW-1:0] resp_data;

  modport master (
    output req_valid, req_cmd, req_dstaddr, req_srcaddr, req_data, resp_ready,
    input  req_ready, resp_valid, resp_cmd, resp_dstaddr, resp_srcaddr, resp_data
  );

  modport slave (
    input  req_valid, req_cmd, req_dstaddr, req_srcaddr, req_data, resp_ready,
    output req_ready, resp_valid, resp_cmd, resp_dstaddr, resp_srcaddr, resp_data
  );
endinterface

// File: rtl/umi_mport_ram.sv
// rtl/umi_mport_ram.sv - N-port UMI memory endpoint sharing one single-ported RAM
// Optional macro UMI_RAM_ERR_RESP_EN: odd unsupported opcodes answer with RESP_ERROR.
module umi_mport_ram #(
  parameter int N        = 5,
  parameter int CW       = 32,
  parameter int AW       = 64,
  parameter int DW       = 256,
  parameter int RAMDEPTH = 512,
  parameter int CTRLW    = 8
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic [1:0]       mode,
  input  logic [CTRLW-1:0] sram_ctrl,
  umi_mport_ram_if.slave   udev
);
  localparam int NB = DW / 8;
  localparam int OW = $clog2(NB);
  localparam int IW = $clog2(RAMDEPTH);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  localparam logic [4:0] OP_READ       = 5'h01;
  localparam logic [4:0] OP_WRITE      = 5'h03;
  localparam logic [4:0] OP_POSTED     = 5'h05;
  localparam logic [4:0] OP_RESP_READ  = 5'h02;
  localparam logic [4:0] OP_RESP_WRITE = 5'h04;
  localparam logic [4:0] OP_RESP_ERR   = 5'h0E;

  logic [DW-1:0]   r_mem [RAMDEPTH];
  logic [N-1:0]    r_resp_valid;
  logic [N*CW-1:0] r_resp_cmd;
  logic [N*AW-1:0] r_resp_dst;
  logic [N*AW-1:0] r_resp_src;
  logic [N*DW-1:0] r_resp_data;
  logic [PW-1:0]   r_ptr;

  logic [N-1:0]  w_elig;
  logic [N-1:0]  w_grant;
  logic          w_any;
  logic [PW-1:0] w_idx;
  logic [PW-1:0] w_start;
  logic [CW-1:0] w_cmd;
  logic [AW-1:0] w_dst;
  logic [AW-1:0] w_src;
  logic [DW-1:0] w_data;
  logic [4:0]    w_op;
  logic [OW-1:0] w_off;
  logic [IW-1:0] w_word;
  logic [16:0]   w_bytes;
  logic [NB-1:0] w_be;
  logic [DW-1:0] w_wdata;
  logic [DW-1:0] w_rshift;
  logic [DW-1:0] w_rdata;
  logic          w_is_wr;
  logic          w_is_rd;
  logic          w_has_resp;
  logic [4:0]    w_resp_op;
  logic          w_unused;

  assign w_unused = ^sram_ctrl;

  // A posted write never needs the response slot, so it bypasses backpressure.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < N; i++) begin
      w_elig[i] = udev.req_valid[i] &
                  ((udev.req_cmd[i*CW +: 5] == OP_POSTED) | !r_resp_valid[i] | udev.resp_ready[i]);
    end
  end

  assign w_start = (mode == 2'b00) ? '0 : ((r_ptr == PW'(N-1)) ? '0 : PW'(r_ptr + 1'b1));

  always_comb begin
    w_grant = '0;
    w_any   = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      int c;
      c = int'(w_start) + k;
      if (c >= N) c = c - N;
      if (!w_any && w_elig[c]) begin
        w_any = 1'b1;
        w_idx = PW'(c);
      end
    end
    if (w_any) w_grant[w_idx] = 1'b1;
  end

  assign w_cmd   = udev.req_cmd[w_idx*CW +: CW];
  assign w_dst   = udev.req_dstaddr[w_idx*AW +: AW];
  assign w_src   = udev.req_srcaddr[w_idx*AW +: AW];
  assign w_data  = udev.req_data[w_idx*DW +: DW];
  assign w_op    = w_cmd[4:0];
  assign w_off   = w_dst[OW-1:0];
  assign w_word  = w_dst[OW +: IW];
  assign w_bytes = {8'b0, ({1'b0, w_cmd[15:8]} + 9'd1)} << w_cmd[7:5];

  assign w_is_wr = w_any && ((w_op == OP_WRITE) || (w_op == OP_POSTED));
  assign w_is_rd = (w_op == OP_READ);

`ifdef UMI_RAM_ERR_RESP_EN
  always_comb begin
    w_has_resp = 1'b0;
    w_resp_op  = OP_RESP_WRITE;
    if (w_is_rd) begin
      w_has_resp = 1'b1;
      w_resp_op  = OP_RESP_READ;
    end else if (w_op == OP_WRITE) begin
      w_has_resp = 1'b1;
    end else if (w_op[0] && (w_op != OP_POSTED)) begin
      w_has_resp = 1'b1;
      w_resp_op  = OP_RESP_ERR;
    end
  end
`else
  assign w_has_resp = w_is_rd || (w_op == OP_WRITE);
  assign w_resp_op  = w_is_rd ? OP_RESP_READ : OP_RESP_WRITE;
`endif

  // Bytes past the end of the word fall off the shifts, which clips transfers at the word edge.
  assign w_wdata  = w_data << {w_off, 3'b000};
  assign w_rshift = r_mem[w_word] >> {w_off, 3'b000};

  always_comb begin
    w_be    = '0;
    w_rdata = '0;
    for (int b = 0; b < NB; b++) begin
      w_be[b]          = (b >= int'(w_off)) && ((b - int'(w_off)) < int'(w_bytes));
      w_rdata[b*8 +: 8] = (b < int'(w_bytes)) ? w_rshift[b*8 +: 8] : 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (w_is_wr) begin
      for (int b = 0; b < NB; b++) begin
        if (w_be[b]) r_mem[w_word][b*8 +: 8] <= w_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_resp_valid <= '0;
      r_resp_cmd   <= '0;
      r_resp_dst   <= '0;
      r_resp_src   <= '0;
      r_resp_data  <= '0;
      r_ptr        <= PW'(N-1);
    end else begin
      if (w_any) r_ptr <= w_idx;
      for (int i = 0; i < N; i++) begin
        if (w_grant[i] && w_has_resp) begin
          r_resp_valid[i]          <= 1'b1;
          r_resp_cmd[i*CW +: CW]   <= {w_cmd[CW-1:5], w_resp_op};
          r_resp_dst[i*AW +: AW]   <= w_src;
          r_resp_src[i*AW +: AW]   <= w_dst;
          r_resp_data[i*DW +: DW]  <= w_is_rd ? w_rdata : '0;
        end else if (udev.resp_ready[i]) begin
          r_resp_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign udev.req_ready    = w_grant;
  assign udev.resp_valid   = r_resp_valid;
  assign udev.resp_cmd     = r_resp_cmd;
  assign udev.resp_dstaddr = r_resp_dst;
  assign udev.resp_srcaddr = r_resp_src;
  assign udev.resp_data    = r_resp_data;
endmodule

// File: tb/tb_umi_mport_ram.sv
// tb/tb_umi_mport_ram.sv - directed self-checking bench for umi_mport_ram
module tb_umi_mport_ram;
  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] sram_ctrl = 8'h00;
  int n_chk = 0;
  int n_fail = 0;

  umi_mport_ram_if #(.N(5), .CW(32), .AW(64), .DW(256)) udev ();

  umi_mport_ram #(.N(5), .CW(32), .AW(64), .DW(256), .RAMDEPTH(512), .CTRLW(8)) dut (
    .clk(clk),
    .nreset(nreset),
    .mode(mode),
    .sram_ctrl(sram_ctrl),
    .udev(udev)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rdata(input int p);
    return udev.resp_data[p*256 +: 256];
  endfunction

  task automatic set_req(input int p, input logic [31:0] cmd, input logic [63:0] dst,
                         input logic [63:0] src, input logic [255:0] data);
    udev.req_cmd[p*32 +: 32]     = cmd;
    udev.req_dstaddr[p*64 +: 64] = dst;
    udev.req_srcaddr[p*64 +: 64] = src;
    udev.req_data[p*256 +: 256]  = data;
    udev.req_valid[p]            = 1'b1;
  endtask

  task automatic issue(input int p, input logic [31:0] cmd, input logic [63:0] dst,
                       input logic [63:0] src, input logic [255:0] data);
    logic [4:0] e;
    e = 5'b00001 << p;
    @(negedge clk);
    set_req(p, cmd, dst, src, data);
    #1 check("req_ready_single", udev.req_ready, e);
    @(posedge clk);
    #1 udev.req_valid[p] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nreset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nreset = 1'b1;
  endtask

  initial begin
    udev.req_valid   = '0;
    udev.req_cmd     = '0;
    udev.req_dstaddr = '0;
    udev.req_srcaddr = '0;
    udev.req_data    = '0;
    udev.resp_ready  = '1;
    do_reset();
    #1;
    check("rst_resp_valid", udev.resp_valid, 5'b0);
    check("rst_req_ready", udev.req_ready, 5'b0);
    check("rst_resp_cmd", udev.resp_cmd[31:0], 0);
    check("rst_resp_data", rdata(0), 0);

    // write then read back on another port
    issue(0, 32'h63, 64'h40, 64'h1000, 256'h1122334455667788);
    check("wr_resp_valid", udev.resp_valid, 5'b00001);
    check("wr_resp_cmd", udev.resp_cmd[31:0], 32'h64);
    check("wr_resp_dst", udev.resp_dstaddr[63:0], 64'h1000);
    check("wr_resp_src", udev.resp_srcaddr[63:0], 64'h40);
    check("wr_resp_data", rdata(0), 0);
    issue(3, 32'h61, 64'h40, 64'h2000, 0);
    check("rd_resp_valid", udev.resp_valid, 5'b01000);
    check("rd_resp_cmd", udev.resp_cmd[3*32 +: 32], 32'h62);
    check("rd_resp_data", rdata(3), 256'h1122334455667788);

    // posted byte write, then byte and word readback
    issue(1, 32'h05, 64'h45, 64'h0, 256'hAB);
    check("posted_no_resp", udev.resp_valid, 5'b0);
    issue(1, 32'h01, 64'h45, 64'h0, 0);
    check("posted_byte", rdata(1), 256'hAB);
    issue(1, 32'h61, 64'h40, 64'h0, 0);
    check("posted_neighbours", rdata(1), 256'h1122AB4455667788);

    // round-robin from a fresh pointer
    do_reset();
    mode = 2'b10;
    @(negedge clk);
    for (int i = 0; i < 5; i++) set_req(i, 32'h61, 64'h40, 64'(i), 0);
    for (int k = 0; k < 5; k++) begin
      logic [4:0] e;
      e = 5'b00001 << k;
      #1 check("rr_grant", udev.req_ready, e);
      @(posedge clk);
      #1 check("rr_resp_valid", udev.resp_valid[k], 1'b1);
      udev.req_valid[k] = 1'b0;
      @(negedge clk);
    end

    // fixed priority starves ports 1-4 while port 0 streams
    mode = 2'b00;
    for (int i = 0; i < 5; i++) udev.req_valid[i] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 check("fixed_starve", udev.req_ready, 5'b00001);
      @(negedge clk);
    end
    udev.req_valid = '0;

    // backpressure on port 2
    mode = 2'b10;
    udev.resp_ready[2] = 1'b0;
    issue(2, 32'h61, 64'h40, 64'h22, 0);
    check("bp_first", rdata(2), 256'h1122AB4455667788);
    @(negedge clk);
    set_req(2, 32'h61, 64'h0, 64'h0, 0);
    set_req(1, 32'h61, 64'h40, 64'h0, 0);
    #1 check("bp_grant_other", udev.req_ready, 5'b00010);
    @(posedge clk);
    #1 check("bp_hold_valid", udev.resp_valid[2], 1'b1);
    check("bp_hold_data", rdata(2), 256'h1122AB4455667788);
    check("bp_other_data", rdata(1), 256'h1122AB4455667788);
    udev.req_valid[1] = 1'b0;
    @(negedge clk);
    #1 check("bp_blocked", udev.req_ready, 5'b00000);
    udev.resp_ready[2] = 1'b1;
    #1 check("bp_drain_grant", udev.req_ready, 5'b00100);
    @(posedge clk);
    #1 udev.req_valid[2] = 1'b0;

    // aliasing and word-end clipping
    issue(0, 32'h23, 64'h0, 64'h0, 256'h5A5A);
    issue(4, 32'h21, 64'h4000, 64'h0, 0);
    check("alias_read", rdata(4), 256'h5A5A);
    issue(0, 32'h43, 64'h1E, 64'h0, 256'hDDCCBBAA);
    issue(1, 32'h41, 64'h1E, 64'h0, 0);
    check("word_end_clip", rdata(1), 256'hBBAA);

    // asynchronous reset drops pending responses
    udev.resp_ready[0] = 1'b0;
    issue(0, 32'h21, 64'h0, 64'h0, 0);
    check("pend_valid", udev.resp_valid[0], 1'b1);
    @(negedge clk);
    #2 nreset = 1'b0;
    #1 check("async_rst_valid", udev.resp_valid, 5'b0);
    udev.resp_ready[0] = 1'b1;
    @(negedge clk);
    nreset = 1'b1;
    issue(0, 32'h21, 64'h4000, 64'h77, 0);
    check("post_rst_read", rdata(0), 256'h5A5A);
    check("post_rst_dst", udev.resp_dstaddr[63:0], 64'h77);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
